clk_src_failover_ctrl: RTL and testbench

// Sequences the 320 MHz fast-command clock source selection for the clock/FC mux.

---
 rtl/clk_src_failover_ctrl_if.sv | 30 +++
 rtl/clk_src_failover_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_clk_src_failover_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/clk_src_failover_ctrl_if.sv
// ----------------------------------------------------------------------------
// clk_src_failover_ctrl_if
// Control/status bundle between the clock-source failover controller and its
// surroundings (clk_ext monitor, register block, BUFGCTRL / FC mux).
//   master : register/monitor side, drives the qualifiers and reads status
//   slave  : the failover controller itself
// ----------------------------------------------------------------------------
interface clk_src_failover_ctrl_if;
    logic        ext_stopped;
    logic [23:0] ext_rate;
    logic        ext_rate_valid;
    logic        force_int;
    logic        auto_ext_en;
    logic        clk_int_sel;
    logic        fc_blank;
    logic        ext_good;
    logic [2:0]  state;
    logic [15:0] failover_count;
    logic [23:0] last_fail_rate;

    modport master (
        output ext_stopped, ext_rate, ext_rate_valid, force_int, auto_ext_en,
        input  clk_int_sel, fc_blank, ext_good, state, failover_count, last_fail_rate
    );

    modport slave (
        input  ext_stopped, ext_rate, ext_rate_valid, force_int, auto_ext_en,
        output clk_int_sel, fc_blank, ext_good, state, failover_count, last_fail_rate
    );
endinterface

// File: rtl/clk_src_failover_ctrl.sv
// ----------------------------------------------------------------------------
// clk_src_failover_ctrl
// Selects the 320 MHz fast-command clock source. clk_ext is qualified (running
// and inside the rate window for QUAL_CYCLES consecutive cycles) before it is
// selected; loss of clk_ext fails over to clk_int on the very next edge. Every
// select change is bracketed by an fc_blank window so FC_out stays idle while
// the BUFGCTRL changes over. Runs entirely on clk_int.
//
// Optional feature macro: FAILOVER_STATS_EN
//   defined   : failover_count / last_fail_rate record hard failovers
//   undefined : both outputs tie to 0 and no statistics registers exist
// ----------------------------------------------------------------------------
module clk_src_failover_ctrl #(
    parameter int unsigned QUAL_CYCLES  = 1024,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned RATE_MIN     = 319000,
    parameter int unsigned RATE_MAX     = 321000
) (
    input  logic                   clk,
    input  logic                   aresetn,
    clk_src_failover_ctrl_if.slave bus
);

    localparam int unsigned QW = $clog2(QUAL_CYCLES + 1);
    localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [QW-1:0] QUAL_LAST  = QW'(QUAL_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [23:0]   RATE_MIN_C = 24'(RATE_MIN);
    localparam logic [23:0]   RATE_MAX_C = 24'(RATE_MAX);

    typedef enum logic [2:0] {
        S_INT  = 3'd0,
        S_QUAL = 3'd1,
        S_PRE  = 3'd2,
        S_POST = 3'd3,
        S_EXT  = 3'd4
    } state_t;

    typedef enum logic {
        TGT_INT = 1'b0,
        TGT_EXT = 1'b1
    } target_t;

    state_t        state_r;
    state_t        state_nxt;
    target_t       target_r;
    target_t       target_nxt;
    logic [QW-1:0] qual_cnt_r;
    logic [QW-1:0] qual_cnt_nxt;
    logic [BW-1:0] blank_cnt_r;
    logic [BW-1:0] blank_cnt_nxt;
    logic          clk_int_sel_r;
    logic          sel_nxt;
    logic          fc_blank_r;
    logic          fc_blank_nxt;
    logic [23:0]   rate_q_r;
    logic          ext_good_r;
    logic          rate_in_win_s;
    logic          fail_evt_s;

    assign rate_in_win_s = (rate_q_r >= RATE_MIN_C) && (rate_q_r <= RATE_MAX_C);

    // Capture the latest rate measurement and judge clk_ext acceptability.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rate_q_r   <= 24'd0;
            ext_good_r <= 1'b0;
        end else begin
            if (bus.ext_rate_valid) begin
                rate_q_r <= bus.ext_rate;
            end
            ext_good_r <= !bus.ext_stopped && rate_in_win_s;
        end
    end

    // FSM state, counters and registered select/blank outputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r       <= S_INT;
            target_r      <= TGT_INT;
            qual_cnt_r    <= '0;
            blank_cnt_r   <= '0;
            clk_int_sel_r <= 1'b1;
            fc_blank_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt;
            target_r      <= target_nxt;
            qual_cnt_r    <= qual_cnt_nxt;
            blank_cnt_r   <= blank_cnt_nxt;
            clk_int_sel_r <= sel_nxt;
            fc_blank_r    <= fc_blank_nxt;
        end
    end

    // Next-state logic; ext_stopped is checked first so hard failover wins.
    always_comb begin
        state_nxt     = state_r;
        target_nxt    = target_r;
        qual_cnt_nxt  = qual_cnt_r;
        blank_cnt_nxt = blank_cnt_r;
        sel_nxt       = clk_int_sel_r;
        fail_evt_s    = 1'b0;

        case (state_r)
            S_INT: begin
                sel_nxt       = 1'b1;
                qual_cnt_nxt  = '0;
                blank_cnt_nxt = '0;
                if (bus.auto_ext_en && !bus.force_int && ext_good_r) begin
                    state_nxt  = S_QUAL;
                    target_nxt = TGT_EXT;
                end else begin
                    state_nxt  = S_INT;
                end
            end

            S_QUAL: begin
                if (!ext_good_r || bus.force_int || !bus.auto_ext_en) begin
                    state_nxt    = S_INT;
                    qual_cnt_nxt = '0;
                end else if (qual_cnt_r == QUAL_LAST) begin
                    state_nxt     = S_PRE;
                    target_nxt    = TGT_EXT;
                    qual_cnt_nxt  = '0;
                    blank_cnt_nxt = '0;
                end else begin
                    qual_cnt_nxt = qual_cnt_r + QW'(1);
                end
            end

            S_PRE: begin
                if ((target_r == TGT_EXT) && !ext_good_r) begin
                    // clk_ext went bad before we committed: select is still clk_int
                    state_nxt     = S_INT;
                    target_nxt    = TGT_INT;
                    sel_nxt       = 1'b1;
                    blank_cnt_nxt = '0;
                end else if (blank_cnt_r == BLANK_LAST) begin
                    state_nxt     = S_POST;
                    sel_nxt       = (target_r == TGT_INT);
                    blank_cnt_nxt = '0;
                end else begin
                    blank_cnt_nxt = blank_cnt_r + BW'(1);
                end
            end

            S_POST: begin
                if ((target_r == TGT_EXT) && bus.ext_stopped) begin
                    // clk_ext died just after being selected: back to clk_int and
                    // restart the post-switch blanking around the new change
                    sel_nxt       = 1'b1;
                    target_nxt    = TGT_INT;
                    blank_cnt_nxt = '0;
                    fail_evt_s    = 1'b1;
                end else if (blank_cnt_r == BLANK_LAST) begin
                    state_nxt     = (target_r == TGT_EXT) ? S_EXT : S_INT;
                    blank_cnt_nxt = '0;
                end else begin
                    blank_cnt_nxt = blank_cnt_r + BW'(1);
                end
            end

            S_EXT: begin
                sel_nxt = 1'b0;
                if (bus.ext_stopped) begin
                    // no PRE phase: a dead clk_ext cannot be drained gracefully
                    state_nxt     = S_POST;
                    target_nxt    = TGT_INT;
                    sel_nxt       = 1'b1;
                    blank_cnt_nxt = '0;
                    fail_evt_s    = 1'b1;
                end else if (bus.force_int || !bus.auto_ext_en || !ext_good_r) begin
                    state_nxt     = S_PRE;
                    target_nxt    = TGT_INT;
                    blank_cnt_nxt = '0;
                end else begin
                    state_nxt = S_EXT;
                end
            end

            default: begin
                // encodings 5-7: recover to a safe clk_int selection
                state_nxt     = S_INT;
                target_nxt    = TGT_INT;
                sel_nxt       = 1'b1;
                qual_cnt_nxt  = '0;
                blank_cnt_nxt = '0;
            end
        endcase

        fc_blank_nxt = (state_nxt == S_PRE) || (state_nxt == S_POST);
    end

`ifdef FAILOVER_STATS_EN
    logic [15:0] failover_count_r;
    logic [23:0] last_fail_rate_r;

    // Hard-failover statistics: saturating count and rate at the failover.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            failover_count_r <= 16'h0000;
            last_fail_rate_r <= 24'd0;
        end else begin
            if (fail_evt_s) begin
                if (failover_count_r != 16'hFFFF) begin
                    failover_count_r <= failover_count_r + 16'd1;
                end
                last_fail_rate_r <= rate_q_r;
            end
        end
    end

    assign bus.failover_count = failover_count_r;
    assign bus.last_fail_rate = last_fail_rate_r;
`else
    logic stats_unused_s;
    assign stats_unused_s     = fail_evt_s;
    assign bus.failover_count = 16'h0000;
    assign bus.last_fail_rate = 24'd0;
`endif

    assign bus.clk_int_sel = clk_int_sel_r;
    assign bus.fc_blank    = fc_blank_r;
    assign bus.ext_good    = ext_good_r;
    assign bus.state       = state_r;

endmodule

// File: tb/tb_clk_src_failover_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_src_failover_ctrl
// Scoreboard bench: each stimulus step pushes the per-cycle expected
// (state, clk_int_sel, fc_blank, ext_good) tuples; every clock the oldest
// tuple is popped and compared #1 after the rising edge.
// Built with QUAL_CYCLES=8, BLANK_CYCLES=4.
// ----------------------------------------------------------------------------
module tb_clk_src_failover_ctrl;

    localparam logic [2:0] ST_INT  = 3'd0;
    localparam logic [2:0] ST_QUAL = 3'd1;
    localparam logic [2:0] ST_PRE  = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_EXT  = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic       sel;
        logic       bl;
        logic       good;
    } exp_t;

    logic clk;
    logic aresetn;
    exp_t exp_q[$];
    int   chk_cnt;
    int   err_cnt;
    int   cyc;
    logic [15:0] exp_cnt;
    logic [23:0] exp_last;

    clk_src_failover_ctrl_if bus ();

    clk_src_failover_ctrl #(
        .QUAL_CYCLES (8),
        .BLANK_CYCLES(4),
        .RATE_MIN    (319000),
        .RATE_MAX    (321000)
    ) dut (
        .clk    (clk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    // 100 MHz stand-in for clk_int
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] st, input logic sel, input logic bl,
                            input logic good, input int n);
        exp_t e;
        e.st   = st;
        e.sel  = sel;
        e.bl   = bl;
        e.good = good;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            check_eq($sformatf("sb_empty@%0d", cyc), exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("state@%0d", cyc), bus.state, e.st);
            check_eq($sformatf("clk_int_sel@%0d", cyc), bus.clk_int_sel, e.sel);
            check_eq($sformatf("fc_blank@%0d", cyc), bus.fc_blank, e.bl);
            check_eq($sformatf("ext_good@%0d", cyc), bus.ext_good, e.good);
        end
    endtask

    task automatic check_stats(input string tag);
        check_eq({tag, "_failover_count"}, bus.failover_count, exp_cnt);
        check_eq({tag, "_last_fail_rate"}, bus.last_fail_rate, exp_last);
    endtask

    initial begin
        clk                = 1'b0;
        aresetn            = 1'b0;
        chk_cnt            = 0;
        err_cnt            = 0;
        cyc                = 0;
        exp_cnt            = 16'd0;
        exp_last           = 24'd0;
        bus.ext_stopped    = 1'b0;
        bus.ext_rate       = 24'd0;
        bus.ext_rate_valid = 1'b0;
        bus.force_int      = 1'b0;
        bus.auto_ext_en    = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", bus.state, ST_INT);
        check_eq("rst_clk_int_sel", bus.clk_int_sel, 1);
        check_eq("rst_fc_blank", bus.fc_blank, 0);
        check_eq("rst_ext_good", bus.ext_good, 0);
        check_stats("rst");
        aresetn = 1'b1;

        // qualify and switch to ext: rate_q then ext_good each take one edge
        bus.auto_ext_en    = 1'b1;
        bus.ext_rate       = 24'd320000;
        bus.ext_rate_valid = 1'b1;
        push_exp(ST_INT,  1'b1, 1'b0, 1'b0, 1);
        push_exp(ST_INT,  1'b1, 1'b0, 1'b1, 1);
        push_exp(ST_QUAL, 1'b1, 1'b0, 1'b1, 8);
        push_exp(ST_PRE,  1'b1, 1'b1, 1'b1, 4);
        push_exp(ST_POST, 1'b0, 1'b1, 1'b1, 4);
        push_exp(ST_EXT,  1'b0, 1'b0, 1'b1, 1);
        tick();
        bus.ext_rate_valid = 1'b0;
        repeat (18) tick();
        check_stats("qualify");

        // hard failover from S_EXT
        bus.ext_stopped = 1'b1;
        push_exp(ST_POST, 1'b1, 1'b1, 1'b0, 1);
        push_exp(ST_POST, 1'b1, 1'b1, 1'b1, 3);
        push_exp(ST_INT,  1'b1, 1'b0, 1'b1, 1);
        tick();
        bus.ext_stopped = 1'b0;
        bus.auto_ext_en = 1'b0;
        repeat (4) tick();
`ifdef FAILOVER_STATS_EN
        exp_cnt  = 16'd1;
        exp_last = 24'd320000;
`endif
        check_stats("hard_failover");

        // qualification abort at qual_cnt=5, then a full fresh qualification
        bus.auto_ext_en = 1'b1;
        push_exp(ST_QUAL, 1'b1, 1'b0, 1'b1, 5);
        push_exp(ST_QUAL, 1'b1, 1'b0, 1'b0, 1);
        push_exp(ST_INT,  1'b1, 1'b0, 1'b1, 1);
        push_exp(ST_QUAL, 1'b1, 1'b0, 1'b1, 8);
        push_exp(ST_PRE,  1'b1, 1'b1, 1'b1, 4);
        push_exp(ST_POST, 1'b0, 1'b1, 1'b1, 4);
        push_exp(ST_EXT,  1'b0, 1'b0, 1'b1, 1);
        repeat (5) tick();
        bus.ext_stopped = 1'b1;
        tick();
        bus.ext_stopped = 1'b0;
        repeat (18) tick();

        // graceful return via force_int
        bus.force_int = 1'b1;
        push_exp(ST_PRE,  1'b0, 1'b1, 1'b1, 4);
        push_exp(ST_POST, 1'b1, 1'b1, 1'b1, 4);
        push_exp(ST_INT,  1'b1, 1'b0, 1'b1, 2);
        repeat (10) tick();
        check_stats("graceful");
        bus.force_int   = 1'b0;
        bus.auto_ext_en = 1'b0;

        // rate window: 321001 rejected
        bus.ext_rate       = 24'd321001;
        bus.ext_rate_valid = 1'b1;
        push_exp(ST_INT, 1'b1, 1'b0, 1'b1, 1);
        push_exp(ST_INT, 1'b1, 1'b0, 1'b0, 1);
        tick();
        bus.ext_rate_valid = 1'b0;
        tick();
        bus.auto_ext_en = 1'b1;
        push_exp(ST_INT, 1'b1, 1'b0, 1'b0, 4);
        repeat (4) tick();

        // rate window: 319000 accepted
        bus.ext_rate       = 24'd319000;
        bus.ext_rate_valid = 1'b1;
        push_exp(ST_INT,  1'b1, 1'b0, 1'b0, 1);
        push_exp(ST_INT,  1'b1, 1'b0, 1'b1, 1);
        push_exp(ST_QUAL, 1'b1, 1'b0, 1'b1, 1);
        tick();
        bus.ext_rate_valid = 1'b0;
        repeat (2) tick();

        // rate window: 321000 accepted, qualification completes
        bus.ext_rate       = 24'd321000;
        bus.ext_rate_valid = 1'b1;
        push_exp(ST_QUAL, 1'b1, 1'b0, 1'b1, 7);
        push_exp(ST_PRE,  1'b1, 1'b1, 1'b1, 4);
        push_exp(ST_POST, 1'b0, 1'b1, 1'b1, 2);
        tick();
        bus.ext_rate_valid = 1'b0;
        repeat (12) tick();

        // failover inside S_POST(target EXT): blanking restarts for 4 cycles
        bus.ext_stopped = 1'b1;
        push_exp(ST_POST, 1'b1, 1'b1, 1'b0, 1);
        tick();
        bus.ext_stopped = 1'b0;
        bus.auto_ext_en = 1'b0;
        push_exp(ST_POST, 1'b1, 1'b1, 1'b1, 2);
        repeat (2) tick();
`ifdef FAILOVER_STATS_EN
        exp_cnt  = 16'd2;
        exp_last = 24'd321000;
`endif
        check_stats("post_failover");

        // reset mid-switch, checked before any clock edge
        aresetn = 1'b0;
        #1;
        check_eq("mid_rst_state", bus.state, ST_INT);
        check_eq("mid_rst_clk_int_sel", bus.clk_int_sel, 1);
        check_eq("mid_rst_fc_blank", bus.fc_blank, 0);
        check_eq("mid_rst_ext_good", bus.ext_good, 0);
        exp_cnt  = 16'd0;
        exp_last = 24'd0;
        check_stats("mid_rst");
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        push_exp(ST_INT, 1'b1, 1'b0, 1'b0, 2);
        repeat (2) tick();

        check_eq("sb_leftover", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
